// File: rtl/ps2_keyboard_fifo_if.sv
// CPU I/O bus seen by the PS/2 keyboard block: port address, read strobe,
// read-data select/data and the keyboard interrupt line.
interface ps2_keyboard_fifo_if;
  logic [19:0] iAddr;
  logic        iRd;
  logic        oSel;
  logic [7:0]  oData;
  logic        oIrq;

  modport master (output iAddr, iRd, input oSel, oData, oIrq);
  modport slave  (input iAddr, iRd, output oSel, oData, oIrq);
endinterface

// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard receiver: frame capture with odd parity and timeout,
// set-2 to set-1 translation (E0 / F0 prefixes), buffered FIFO read
// through the data port, status byte on the status port, level IRQ.
module ps2_keyboard_fifo #(
  parameter int          FIFO_DEPTH   = 16,
  parameter int          TIMEOUT_BITS = 16,
  parameter logic [11:0] DATA_PORT    = 12'h060,
  parameter logic [11:0] STAT_PORT    = 12'h064
) (
  input  logic                iClk,
  input  logic                iRstN,
  ps2_keyboard_fifo_if.slave  bus,
  input  logic                iPs2Clk,
  input  logic                iPs2Dat
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXTBRK} dec_state_t;

  // Set-2 make code to set-1 make code; 00h marks an untranslatable byte.
  function automatic logic [7:0] xlate(input logic [7:0] c);
    logic [7:0] t;
    case (c)
      8'h01: t = 8'h43; 8'h03: t = 8'h3F; 8'h04: t = 8'h3D; 8'h05: t = 8'h3B; 8'h06: t = 8'h3C; 8'h07: t = 8'h58;
      8'h09: t = 8'h44; 8'h0A: t = 8'h42; 8'h0B: t = 8'h40; 8'h0C: t = 8'h3E; 8'h0D: t = 8'h0F; 8'h0E: t = 8'h29;
      8'h11: t = 8'h38; 8'h12: t = 8'h2A; 8'h14: t = 8'h1D; 8'h15: t = 8'h10; 8'h16: t = 8'h02; 8'h1A: t = 8'h2C;
      8'h1B: t = 8'h1F; 8'h1C: t = 8'h1E; 8'h1D: t = 8'h11; 8'h1E: t = 8'h03; 8'h21: t = 8'h2E; 8'h22: t = 8'h2D;
      8'h23: t = 8'h20; 8'h24: t = 8'h12; 8'h25: t = 8'h05; 8'h26: t = 8'h04; 8'h29: t = 8'h39; 8'h2A: t = 8'h2F;
      8'h2B: t = 8'h21; 8'h2C: t = 8'h14; 8'h2D: t = 8'h13; 8'h2E: t = 8'h06; 8'h31: t = 8'h31; 8'h32: t = 8'h30;
      8'h33: t = 8'h23; 8'h34: t = 8'h22; 8'h35: t = 8'h15; 8'h36: t = 8'h07; 8'h3A: t = 8'h32; 8'h3B: t = 8'h24;
      8'h3C: t = 8'h16; 8'h3D: t = 8'h08; 8'h3E: t = 8'h09; 8'h41: t = 8'h33; 8'h42: t = 8'h25; 8'h43: t = 8'h17;
      8'h44: t = 8'h18; 8'h45: t = 8'h0B; 8'h46: t = 8'h0A; 8'h49: t = 8'h34; 8'h4A: t = 8'h35; 8'h4B: t = 8'h26;
      8'h4C: t = 8'h27; 8'h4D: t = 8'h19; 8'h4E: t = 8'h0C; 8'h52: t = 8'h28; 8'h54: t = 8'h1A; 8'h55: t = 8'h0D;
      8'h58: t = 8'h3A; 8'h59: t = 8'h36; 8'h5A: t = 8'h1C; 8'h5B: t = 8'h1B; 8'h5D: t = 8'h2B; 8'h66: t = 8'h0E;
      8'h69: t = 8'h4F; 8'h6B: t = 8'h4B; 8'h6C: t = 8'h47; 8'h70: t = 8'h52; 8'h71: t = 8'h53; 8'h72: t = 8'h50;
      8'h73: t = 8'h4C; 8'h74: t = 8'h4D; 8'h75: t = 8'h48; 8'h76: t = 8'h01; 8'h77: t = 8'h45; 8'h78: t = 8'h57;
      8'h79: t = 8'h4E; 8'h7A: t = 8'h51; 8'h7B: t = 8'h4A; 8'h7C: t = 8'h37; 8'h7D: t = 8'h49; 8'h7E: t = 8'h46;
      8'h83: t = 8'h41;
      default: t = 8'h00;
    endcase
    return t;
  endfunction

  logic [2:0]              ck_s, dt_s;
  logic [10:0]             shreg;
  logic [10:0]             frame;
  logic [3:0]              bcnt;
  logic [TIMEOUT_BITS-1:0] to_cnt;
  logic                    fall, rx_valid, perr_set;
  logic [7:0]              rx_byte;

  dec_state_t state, state_nxt;
  logic       emit, emit_ext, emit_brk, pair_busy;
  logic [7:0] tcode, emit_code;
  logic       em_vld, em_ext, pend_vld;
  logic [7:0] em_code, pend_code;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, used;
  logic        empty, full, pair_room;
  logic        push, wr_ok, start_pair, ovf_set;
  logic [7:0]  push_data, head, status;
  logic        ovf, perr;

  logic       sel_data, sel_stat, rd_data_q, rd_stat_q, pop_req, pop, stat_rd;
  logic       sel_r, irq_r;
  logic [7:0] data_r;
  logic       unused_addr;

  assign unused_addr = ^bus.iAddr[19:12];

  // The new frame includes the bit arriving on this edge (LSB first, so it enters at the top).
  assign fall  = ck_s[2] & ~ck_s[1];
  assign frame = {dt_s[1], shreg[10:1]};

  // Synchronisers, bit capture, frame check and inter-edge timeout.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      ck_s <= '0; dt_s <= '0; shreg <= '0; bcnt <= '0; to_cnt <= '0;
      rx_valid <= 1'b0; rx_byte <= '0; perr_set <= 1'b0;
    end else begin
      ck_s     <= {ck_s[1:0], iPs2Clk};
      dt_s     <= {dt_s[1:0], iPs2Dat};
      rx_valid <= 1'b0;
      perr_set <= 1'b0;
      if (fall) begin
        to_cnt <= '0;
        shreg  <= frame;
        if (bcnt == 4'd10) begin
          bcnt <= '0;
          // Bad start/stop is dropped silently; only a well-framed byte can flag parity.
          if (!frame[0] && frame[10]) begin
            if (^frame[9:1]) begin
              rx_valid <= 1'b1;
              rx_byte  <= frame[8:1];
            end else begin
              perr_set <= 1'b1;
            end
          end
        end else begin
          bcnt <= bcnt + 4'd1;
        end
      end else if (&to_cnt) begin
        if (bcnt != 4'd0) bcnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

  // Decoder state register.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state <= IDLE;
    else        state <= state_nxt;
  end

  // Prefix tracking and translation; bytes are ignored while an E0 pair is still being pushed.
  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_brk  = 1'b0;
    tcode     = xlate(rx_byte);
    if (rx_valid && !pair_busy) begin
      state_nxt = IDLE;
      case (state)
        IDLE: begin
          if (rx_byte == 8'hE0)      state_nxt = EXT;
          else if (rx_byte == 8'hF0) state_nxt = BRK;
          else                       emit = (tcode != 8'h00);
        end
        EXT: begin
          if (rx_byte == 8'hF0) state_nxt = EXTBRK;
          else begin emit = (tcode != 8'h00); emit_ext = 1'b1; end
        end
        BRK:     begin emit = (tcode != 8'h00); emit_brk = 1'b1; end
        default: begin emit = (tcode != 8'h00); emit_ext = 1'b1; emit_brk = 1'b1; end
      endcase
    end
  end

  assign emit_code = tcode | {emit_brk, 7'b0};
  assign pair_busy = (em_vld & em_ext) | pend_vld;

  assign used      = wp - rp;
  assign empty     = (wp == rp);
  assign full      = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign pair_room = (used <= (AW+1)'(FIFO_DEPTH - 2));
  assign head      = empty ? 8'h00 : mem[rp[AW-1:0]];
  assign status    = {4'b0000, full, perr, ovf, ~empty};

  assign sel_data = bus.iRd && (bus.iAddr[11:0] == DATA_PORT);
  assign sel_stat = bus.iRd && (bus.iAddr[11:0] == STAT_PORT);
  assign pop_req  = sel_data & ~rd_data_q;
  assign pop      = pop_req & ~empty;
  assign stat_rd  = sel_stat & ~rd_stat_q;

  // Push selection: second half of a pair, else a fresh single or E0-prefixed code.
  always_comb begin
    push       = 1'b0;
    push_data  = em_code;
    start_pair = 1'b0;
    ovf_set    = 1'b0;
    if (pend_vld) begin
      push      = 1'b1;
      push_data = pend_code;
    end else if (em_vld) begin
      if (!em_ext) begin
        push = 1'b1;
      end else if (pair_room) begin
        push       = 1'b1;
        push_data  = 8'hE0;
        start_pair = 1'b1;
      end else begin
        ovf_set = 1'b1;
      end
    end
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    wr_ok = push & (~full | pop);
    if (push && !wr_ok) ovf_set = 1'b1;
  end

  // FIFO storage.
  always_ff @(posedge iClk) begin
    if (wr_ok) mem[wp[AW-1:0]] <= push_data;
  end

  // Pointers, sticky flags, push staging and the registered bus outputs.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      wp <= '0; rp <= '0; ovf <= 1'b0; perr <= 1'b0;
      em_vld <= 1'b0; em_ext <= 1'b0; em_code <= '0;
      pend_vld <= 1'b0; pend_code <= '0;
      rd_data_q <= 1'b0; rd_stat_q <= 1'b0;
      sel_r <= 1'b0; data_r <= '0; irq_r <= 1'b0;
    end else begin
      em_vld    <= emit;
      em_ext    <= emit_ext;
      em_code   <= emit_code;
      pend_vld  <= start_pair;
      if (start_pair) pend_code <= em_code;
      if (wr_ok) wp <= wp + (AW+1)'(1);
      if (pop)   rp <= rp + (AW+1)'(1);
      ovf       <= ovf_set  | (ovf  & ~stat_rd);
      perr      <= perr_set | (perr & ~stat_rd);
      rd_data_q <= sel_data;
      rd_stat_q <= sel_stat;
      irq_r     <= ~empty;
      sel_r     <= sel_data | sel_stat;
      if (pop_req)      data_r <= head;
      else if (stat_rd) data_r <= status;
    end
  end

  assign bus.oSel  = sel_r;
  assign bus.oData = data_r;
  assign bus.oIrq  = irq_r;
endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Directed bench for ps2_keyboard_fifo (FIFO_DEPTH=4, TIMEOUT_BITS=8).
module tb_ps2_keyboard_fifo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_dat = 1'b1;
  int   checks = 0;
  int   errors = 0;

  ps2_keyboard_fifo_if bus ();

  ps2_keyboard_fifo #(.FIFO_DEPTH(4), .TIMEOUT_BITS(8)) dut (
    .iClk(clk), .iRstN(rst_n), .bus(bus), .iPs2Clk(ps2_clk), .iPs2Dat(ps2_dat)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    bus.iRd = 1'b0; bus.iAddr = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (10) @(posedge clk);
    ps2_clk = 1'b0;
    repeat (20) @(posedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(bad_par ? ^b : ~^b);
    ps2_bit(1'b1);
    repeat (20) @(posedge clk);
  endtask

  task automatic read_port(input logic [11:0] a, output logic [7:0] d, output logic s);
    @(negedge clk);
    bus.iAddr = {8'h00, a};
    bus.iRd   = 1'b1;
    @(negedge clk);
    d = bus.oData;
    s = bus.oSel;
    bus.iRd = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++; if (bus.oIrq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", bus.oIrq); end
    checks++; if (bus.oSel !== 1'b0) begin errors++; $display("FAIL reset_sel: got %b want 0", bus.oSel); end
    checks++; if (bus.oData !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", bus.oData); end
    do_reset();
  endtask

  task automatic test_make();
    logic [7:0] d; logic s;
    do_reset();
    send_byte(8'h1C, 1'b0);
    checks++; if (bus.oIrq !== 1'b1) begin errors++; $display("FAIL make_irq: got %b want 1", bus.oIrq); end
    read_port(12'h060, d, s);
    checks++; if (d !== 8'h1E) begin errors++; $display("FAIL make_data: got %h want 1e", d); end
    checks++; if (s !== 1'b1) begin errors++; $display("FAIL make_sel: got %b want 1", s); end
    checks++; if (bus.oIrq !== 1'b1) begin errors++; $display("FAIL make_irq_lag: got %b want 1", bus.oIrq); end
    @(negedge clk);
    checks++; if (bus.oIrq !== 1'b0) begin errors++; $display("FAIL make_irq_clear: got %b want 0", bus.oIrq); end
    repeat (2) @(negedge clk);
    checks++; if (bus.oSel !== 1'b0) begin errors++; $display("FAIL make_sel_idle: got %b want 0", bus.oSel); end
    checks++; if (bus.oData !== 8'h1E) begin errors++; $display("FAIL make_data_hold: got %h want 1e", bus.oData); end
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL make_status: got %h want 00", d); end
  endtask

  task automatic test_break_ext();
    logic [7:0] d; logic s;
    logic [7:0] exp_q [5];
    exp_q = '{8'hE0, 8'h48, 8'hE0, 8'hC8, 8'h00};
    do_reset();
    send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL brk_status: got %h want 01", d); end
    read_port(12'h060, d, s);
    checks++; if (d !== 8'h9E) begin errors++; $display("FAIL brk_data: got %h want 9e", d); end
    read_port(12'h060, d, s);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL brk_empty: got %h want 00", d); end
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h09) begin errors++; $display("FAIL ext_status: got %h want 09", d); end
    for (int i = 0; i < 5; i++) begin
      read_port(12'h060, d, s);
      checks++; if (d !== exp_q[i]) begin errors++; $display("FAIL ext_read%0d: got %h want %h", i, d, exp_q[i]); end
    end
  endtask

  task automatic test_parity();
    logic [7:0] d; logic s;
    do_reset();
    send_byte(8'h1C, 1'b1);
    checks++; if (bus.oIrq !== 1'b0) begin errors++; $display("FAIL par_irq: got %b want 0", bus.oIrq); end
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL par_status: got %h want 04", d); end
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL par_status_clr: got %h want 00", d); end
  endtask

  task automatic test_overflow();
    logic [7:0] d; logic s;
    logic [7:0] sc [5];
    logic [7:0] exp_q [5];
    sc    = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24};
    exp_q = '{8'h1E, 8'h30, 8'h2E, 8'h20, 8'h00};
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(sc[i], 1'b0);
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h0B) begin errors++; $display("FAIL ovf_status: got %h want 0b", d); end
    for (int i = 0; i < 5; i++) begin
      read_port(12'h060, d, s);
      checks++; if (d !== exp_q[i]) begin errors++; $display("FAIL ovf_read%0d: got %h want %h", i, d, exp_q[i]); end
    end
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL ovf_status_clr: got %h want 00", d); end
  endtask

  task automatic test_pair_ovf();
    logic [7:0] d; logic s;
    logic [7:0] exp_q [4];
    exp_q = '{8'h1E, 8'h30, 8'h2E, 8'h00};
    do_reset();
    send_byte(8'h1C, 1'b0); send_byte(8'h32, 1'b0); send_byte(8'h21, 1'b0);
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL pair_status: got %h want 03", d); end
    for (int i = 0; i < 4; i++) begin
      read_port(12'h060, d, s);
      checks++; if (d !== exp_q[i]) begin errors++; $display("FAIL pair_read%0d: got %h want %h", i, d, exp_q[i]); end
    end
  endtask

  task automatic test_hold();
    logic [7:0] d; logic s;
    do_reset();
    send_byte(8'h1C, 1'b0); send_byte(8'h32, 1'b0);
    @(negedge clk);
    bus.iAddr = 20'h00060; bus.iRd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (bus.oData !== 8'h1E) begin errors++; $display("FAIL hold_data%0d: got %h want 1e", i, bus.oData); end
    end
    bus.iRd = 1'b0;
    read_port(12'h060, d, s);
    checks++; if (d !== 8'h30) begin errors++; $display("FAIL hold_next: got %h want 30", d); end
    read_port(12'h060, d, s);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL hold_empty: got %h want 00", d); end
  endtask

  task automatic test_timeout();
    logic [7:0] d; logic s;
    do_reset();
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
    repeat (300) @(posedge clk);
    send_byte(8'h76, 1'b0);
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL to_status: got %h want 01", d); end
    read_port(12'h060, d, s);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL to_data: got %h want 01", d); end
    read_port(12'h060, d, s);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL to_empty: got %h want 00", d); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d; logic s;
    do_reset();
    send_byte(8'h1C, 1'b0);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.oIrq !== 1'b0) begin errors++; $display("FAIL rstmid_irq: got %b want 0", bus.oIrq); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    read_port(12'h064, d, s);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rstmid_status: got %h want 00", d); end
    send_byte(8'h5A, 1'b0);
    read_port(12'h060, d, s);
    checks++; if (d !== 8'h1C) begin errors++; $display("FAIL rstmid_data: got %h want 1c", d); end
  endtask

  initial begin
    bus.iAddr = '0;
    bus.iRd   = 1'b0;
    test_reset();
    test_make();
    test_break_ext();
    test_parity();
    test_overflow();
    test_pair_ovf();
    test_hold();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_keyboard_fifo.md
Name: ps2_keyboard_fifo

Overview:
- PS/2 keyboard receiver with odd-parity check, frame timeout and a set-2 to XT set-1 translator that handles E0-extended keys and F0 break codes.
- Translated bytes are buffered in a parametrised FIFO and read by the CPU through port 60h. Port 64h provides a status byte.
- oIrq is level-high while data is pending.
- Sits on the CPU I/O bus next to the PIC, in place of the unbuffered single-byte keyboard port.

Parameters:
- FIFO_DEPTH, 16, entry count; power of 2, minimum 4.
- TIMEOUT_BITS, 16, width of the inter-edge timeout counter; a partial frame is dropped after 2^TIMEOUT_BITS-1 idle cycles.
- DATA_PORT, 12'h060, I/O address (iAddr[11:0]) of the data port.
- STAT_PORT, 12'h064, I/O address (iAddr[11:0]) of the status port.

Ports:
- iClk  in  1  system clock
- iRstN  in  1  asynchronous active-low reset
- iAddr  in  20  CPU port address
- iRd  in  1  CPU port read strobe
- oSel  out  1  this block drives the read data bus this cycle
- oData  out  8  read data
- oIrq  out  1  high while the FIFO is non-empty
- iPs2Clk  in  1  PS/2 clock, asynchronous
- iPs2Dat  in  1  PS/2 data, asynchronous

Behaviour:
- Reset (iRstN=0, asynchronous): all state clears.
  - FIFO empty; oSel=0, oData=00h, oIrq=0.
  - Sticky flags 0, decoder in IDLE, bit counter 0.
- Sync:
  - iPs2Clk and iPs2Dat each pass through a 3-flop synchroniser.
  - A falling edge is sync[2]=1 and sync[1]=0; data is sampled from the aligned stage on that edge.
- Frame:
  - 11 bits, LSB first, shifted in on each falling edge.
  - At count 11, count returns to 0 and the frame is checked: start=0, stop=1, XOR(D7..D0,P)=1.
  - A valid frame produces a 1-cycle rx_valid with the byte.
  - A parity failure sets PERR. A start or stop failure discards the frame silently.
- Timeout:
  - The counter clears on every falling edge and saturates at all-ones.
  - At all-ones with count≠0, count resets to 0 and the partial frame is lost.
- Decoder FSM:
  - States are IDLE, EXT, BRK and EXTBRK.
  - In IDLE: E0→EXT, F0→BRK, any other byte→translate and emit with brk=0, ext=0.
  - In EXT: F0→EXTBRK; any other byte→emit with ext=1.
  - In BRK: any byte→emit with brk=1.
  - In EXTBRK: any byte→emit with ext=1, brk=1.
  - Every emit returns the FSM to IDLE.
  - E1 and any byte not in the table (translation=00h) are dropped, and the FSM returns to IDLE.
- Translation:
  - The team's standard set-2→set-1 table (e.g. 1Ch→1Eh, 76h→01h, 75h→48h, 5Ah→1Ch).
  - The extended form uses the same table: E0 75 → E0 48, E0 F0 75 → E0 C8.
  - Emitted code = table | (brk<<7).
- Push:
  - ext=0: one push on the cycle after rx_valid.
  - ext=1: E0h is pushed first, the code on the next cycle.
  - The pair is atomic: if free slots < 2, neither byte is pushed and OVF is set.
  - Single push into a full FIFO: the byte is dropped and OVF is set.
  - The decoder accepts no new byte while a pair is in flight. Frames arrive at ≥800 cycles apart, so no loss results.
- Read timing:
  - oSel is registered and asserts 1 cycle after iRd is high with a matching address.
  - oData is valid in the same cycle as oSel. oData holds its value when oSel=0.
- Data port:
  - A read returns the FIFO head, or 00h if the FIFO is empty.
  - Pop happens once per read, on the first cycle of iRd (rising edge of the qualified strobe). Holding iRd does not pop again.
- Status port:
  - Byte layout: bit0=OBF (FIFO non-empty), bit1=OVF, bit2=PERR, bit3=FULL, bits7:4=0.
  - Reading it clears OVF and PERR. A set event in the same cycle wins.
- Simultaneous push and pop:
  - Both occur; the count is unchanged. This holds even when the FIFO is full: pop first, so the push succeeds.
- Pointers:
  - Width log2(FIFO_DEPTH)+1, wrapping naturally.
  - Full = MSBs differ and the rest are equal. Empty = all bits equal.
- oIrq = OBF, registered, 1 cycle after the FIFO state changes.

Test Plan:
- Frame for 1Ch (make A), correct odd parity → FIFO holds 1Eh, oIrq=1. Read 60h → oData=1Eh, oIrq=0 two cycles later. Read 64h → 00h.
- Bytes F0,1C → single entry 9Eh. Bytes E0,75 then E0,F0,75 → reads in order E0,48,E0,C8.
- Frame 1Ch with bad parity → no push, no IRQ. Read 64h → 04h; second read 64h → 00h.
- FIFO_DEPTH=4: send 5 plain makes, then read 64h → 0Bh. Reads of 60h return the first 4 codes in order, then 00h.
- FIFO_DEPTH=4 holding 3 entries, send E0,75 → nothing pushed, OVF=1.
- 6 clock edges then idle past timeout, then a valid 76h frame → exactly one entry 01h.
- iRstN pulsed low mid-frame and with the FIFO non-empty → oIrq=0 and status 00h at once. The next complete frame decodes correctly.
